// File: rtl/dice_input_stage_if.sv
// Button/switch bundle and conditioned controller levels for dice_input_stage.
// The stage itself connects through the slave modport.
interface dice_input_stage_if;
   logic       btn_start;
   logic       btn_enter;
   logic       btn_roll;
   logic [4:0] sw_value;
   logic       start;
   logic       valid_dice;
   logic       valid_target;
   logic       roll;
   logic [4:0] sides;
   logic [4:0] target;
   logic       error;
   logic       new_game;

   modport master (
      output btn_start, btn_enter, btn_roll, sw_value,
      input  start, valid_dice, valid_target, roll, sides, target, error, new_game
   );

   modport slave (
      input  btn_start, btn_enter, btn_roll, sw_value,
      output start, valid_dice, valid_target, roll, sides, target, error, new_game
   );
endinterface

// File: rtl/dice_input_stage.sv
// Dice game front end: sync/debounce/edge-detect buttons, validate entries, hold levels.
// Optional macro DICE_INPUT_DEBOUNCE_EN builds the per-button debounce counters.
module dice_input_stage #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input logic               clock,
   input logic               reset,
   dice_input_stage_if.slave io
);

   typedef enum logic [2:0] {IDLE, GET_SIDES, GET_TARGET, ARMED, DONE} state_t;

   // button bit order everywhere: [2]=start, [1]=enter, [0]=roll
   logic [2:0] btn_raw;
   logic [2:0] btn_s1_q, btn_s2_q;
   logic [2:0] lvl_q, lvl_d;
   logic [2:0] rise;
   logic [2:0] press_q, press_d;
   logic [4:0] sw_s1_q, sw_s2_q;

   state_t     state_q, state_d;
   logic       start_q, start_d;
   logic       vdice_q, vdice_d;
   logic       vtgt_q, vtgt_d;
   logic       roll_q, roll_d;
   logic [4:0] sides_q, sides_d;
   logic [4:0] target_q, target_d;
   logic       error_q, error_d;
   logic       newg_q, newg_d;
   logic       sides_legal;

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_param_chk
      $error("DEBOUNCE_CYCLES must be within 1..255");
   end

   assign btn_raw = {io.btn_start, io.btn_enter, io.btn_roll};

`ifdef DICE_INPUT_DEBOUNCE_EN
   localparam logic [7:0] DB_N = DEBOUNCE_CYCLES[7:0];
   logic [2:0][7:0] cnt_q, cnt_d;

   // level flips on the edge after the count has been seen at DB_N
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      for (int i = 0; i < 3; i++) begin
         if (btn_s2_q[i] != lvl_q[i]) begin
            if (cnt_q[i] == DB_N) lvl_d[i] = btn_s2_q[i];
            else                  cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   always_comb lvl_d = btn_s2_q;
`endif

   assign rise = lvl_d & ~lvl_q;

   always_comb begin
      press_d = 3'b000;
      if      (rise[2]) press_d = 3'b100;
      else if (rise[1]) press_d = 3'b010;
      else if (rise[0]) press_d = 3'b001;
   end

   always_comb begin
      case (sw_s2_q)
         5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd20: sides_legal = 1'b1;
         default:                               sides_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         lvl_q    <= '0;
         press_q  <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
      end else begin
         btn_s1_q <= btn_raw;
         btn_s2_q <= btn_s1_q;
         lvl_q    <= lvl_d;
         press_q  <= press_d;
         sw_s1_q  <= io.sw_value;
         sw_s2_q  <= sw_s1_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         start_q  <= 1'b0;
         vdice_q  <= 1'b0;
         vtgt_q   <= 1'b0;
         roll_q   <= 1'b0;
         sides_q  <= '0;
         target_q <= '0;
         error_q  <= 1'b0;
         newg_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         vdice_q  <= vdice_d;
         vtgt_q   <= vtgt_d;
         roll_q   <= roll_d;
         sides_q  <= sides_d;
         target_q <= target_d;
         error_q  <= error_d;
         newg_q   <= newg_d;
      end
   end

   // levels hold by default; only the pulses default low
   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      vdice_d  = vdice_q;
      vtgt_d   = vtgt_q;
      roll_d   = roll_q;
      sides_d  = sides_q;
      target_d = target_q;
      error_d  = 1'b0;
      newg_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (press_q[2]) begin
               start_d = 1'b1;
               state_d = GET_SIDES;
            end
         end
         GET_SIDES: begin
            if (press_q[1]) begin
               if (sides_legal) begin
                  sides_d = sw_s2_q;
                  vdice_d = 1'b1;
                  state_d = GET_TARGET;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         GET_TARGET: begin
            if (press_q[1]) begin
               if (sw_s2_q != 5'd0 && sw_s2_q <= sides_q) begin
                  target_d = sw_s2_q;
                  vtgt_d   = 1'b1;
                  state_d  = ARMED;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         ARMED: begin
            if (press_q[0]) begin
               roll_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (press_q[2]) begin
               start_d  = 1'b0;
               vdice_d  = 1'b0;
               vtgt_d   = 1'b0;
               roll_d   = 1'b0;
               sides_d  = '0;
               target_d = '0;
               newg_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign io.start        = start_q;
   assign io.valid_dice   = vdice_q;
   assign io.valid_target = vtgt_q;
   assign io.roll         = roll_q;
   assign io.sides        = sides_q;
   assign io.target       = target_q;
   assign io.error        = error_q;
   assign io.new_game     = newg_q;

endmodule

// File: tb/tb_dice_input_stage.sv
// Self-checking bench for dice_input_stage: fixed game table, corner sequences,
// then randomized presses against a rule-level model of the game.
module tb_dice_input_stage;

   localparam int DB = 4;
`ifdef DICE_INPUT_DEBOUNCE_EN
   localparam int LAT = DB + 4;
`else
   localparam int LAT = 4;
`endif
   localparam int HOLD = LAT + 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   dice_input_stage_if io ();

   dice_input_stage #(.DEBOUNCE_CYCLES(DB)) dut (
      .clock (clock),
      .reset (reset),
      .io    (io)
   );

   always #5 clock = ~clock;

   // {start, valid_dice, valid_target, roll, sides, target, error, new_game}
   logic [15:0] outs;
   assign outs = {io.start, io.valid_dice, io.valid_target, io.roll,
                  io.sides, io.target, io.error, io.new_game};

   function automatic logic [15:0] mk(logic st, logic vd, logic vt, logic rl,
                                      logic [4:0] sd, logic [4:0] tg, logic er, logic ng);
      return {st, vd, vt, rl, sd, tg, er, ng};
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // model: phase counts accepted game steps (0 idle .. 4 rolled)
   int         m_ph;
   logic       m_st, m_vd, m_vt, m_rl;
   logic [4:0] m_sd, m_tg;

   task automatic model_reset();
      m_ph = 0; m_st = 0; m_vd = 0; m_vt = 0; m_rl = 0; m_sd = 0; m_tg = 0;
   endtask

   task automatic model_step(input logic [2:0] mask, input logic [4:0] sw,
                             output logic [15:0] eo, output logic [15:0] en);
      logic er, ng;
      er = 0; ng = 0;
      eo = mk(m_st, m_vd, m_vt, m_rl, m_sd, m_tg, 1'b0, 1'b0);
      if (mask[2]) begin
         if (m_ph == 0) begin
            m_ph = 1; m_st = 1;
         end else if (m_ph == 4) begin
            model_reset(); ng = 1;
         end
      end else if (mask[1]) begin
         if (m_ph == 1) begin
            if (sw inside {5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd20}) begin
               m_sd = sw; m_vd = 1; m_ph = 2;
            end else er = 1;
         end else if (m_ph == 2) begin
            if (int'(sw) >= 1 && int'(sw) <= int'(m_sd)) begin
               m_tg = sw; m_vt = 1; m_ph = 3;
            end else er = 1;
         end
      end else if (mask[0] && m_ph == 3) begin
         m_rl = 1; m_ph = 4;
      end
      en = mk(m_st, m_vd, m_vt, m_rl, m_sd, m_tg, er, ng);
   endtask

   // entered at a negedge; raw buttons go high before edge 1
   task automatic press(input string nm, input logic [2:0] mask, input logic [4:0] sw,
                        input int hold, input logic [15:0] e_old, input logic [15:0] e_new);
      io.sw_value  = sw;
      io.btn_start = mask[2];
      io.btn_enter = mask[1];
      io.btn_roll  = mask[0];
      for (int k = 1; k <= LAT + 1 || k <= hold; k++) begin
         @(posedge clock);
         @(negedge clock);
         if (k == hold) begin
            io.btn_start = 0; io.btn_enter = 0; io.btn_roll = 0;
         end
         if (k == LAT - 1) check({nm, "_pre"}, outs, e_old);
         if (k == LAT)     check(nm, outs, e_new);
         if (k == LAT + 1) check({nm, "_post"}, outs, e_new & ~16'h0003);
      end
      repeat (LAT + 2) @(negedge clock);
   endtask

   task automatic step(input string nm, input logic [2:0] mask, input logic [4:0] sw);
      logic [15:0] eo, en;
      model_step(mask, sw, eo, en);
      press(nm, mask, sw, HOLD, eo, en);
   endtask

   typedef struct {
      string       nm;
      logic [2:0]  mask;
      logic [4:0]  sw;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[15];

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] prev, eo, en;
      logic [2:0]  msk;
      logic [4:0]  sw;
      int          r;

      tbl[0]  = '{"t_start",      3'b100, 5'd0,  mk(1,0,0,0, 5'd0, 5'd0, 0,0)};
      tbl[1]  = '{"t_sides_bad7", 3'b010, 5'd7,  mk(1,0,0,0, 5'd0, 5'd0, 1,0)};
      tbl[2]  = '{"t_sides6",     3'b010, 5'd6,  mk(1,1,0,0, 5'd6, 5'd0, 0,0)};
      tbl[3]  = '{"t_tgt_bad9",   3'b010, 5'd9,  mk(1,1,0,0, 5'd6, 5'd0, 1,0)};
      tbl[4]  = '{"t_tgt_bad0",   3'b010, 5'd0,  mk(1,1,0,0, 5'd6, 5'd0, 1,0)};
      tbl[5]  = '{"t_tgt6",       3'b010, 5'd6,  mk(1,1,1,0, 5'd6, 5'd6, 0,0)};
      tbl[6]  = '{"t_roll",       3'b001, 5'd0,  mk(1,1,1,1, 5'd6, 5'd6, 0,0)};
      tbl[7]  = '{"t_newgame",    3'b100, 5'd0,  mk(0,0,0,0, 5'd0, 5'd0, 0,1)};
      tbl[8]  = '{"t_simul",      3'b110, 5'd8,  mk(1,0,0,0, 5'd0, 5'd0, 0,0)};
      tbl[9]  = '{"t_sides8",     3'b010, 5'd8,  mk(1,1,0,0, 5'd8, 5'd0, 0,0)};
      tbl[10] = '{"t_tgt7",       3'b010, 5'd7,  mk(1,1,1,0, 5'd8, 5'd7, 0,0)};
      tbl[11] = '{"t_armed_ent",  3'b010, 5'd3,  mk(1,1,1,0, 5'd8, 5'd7, 0,0)};
      tbl[12] = '{"t_roll2",      3'b001, 5'd0,  mk(1,1,1,1, 5'd8, 5'd7, 0,0)};
      tbl[13] = '{"t_done_roll",  3'b001, 5'd0,  mk(1,1,1,1, 5'd8, 5'd7, 0,0)};
      tbl[14] = '{"t_newgame2",   3'b100, 5'd0,  mk(0,0,0,0, 5'd0, 5'd0, 0,1)};

      io.btn_start = 0; io.btn_enter = 0; io.btn_roll = 0; io.sw_value = 0;
      reset = 0;
      repeat (3) @(negedge clock);
      check("reset_outs", outs, 16'h0000);
      reset = 1;
      @(negedge clock);

      prev = 16'h0000;
      for (int i = 0; i < 15; i++) begin
         press(tbl[i].nm, tbl[i].mask, tbl[i].sw, HOLD, prev, tbl[i].exp);
         prev = tbl[i].exp & ~16'h0003;
      end

      // asynchronous reset while ARMED
      model_reset();
      step("r_start", 3'b100, 5'd0);
      step("r_sides", 3'b010, 5'd12);
      step("r_tgt",   3'b010, 5'd5);
      #2 reset = 0;
      #1 check("async_reset", outs, 16'h0000);
      model_reset();
      @(negedge clock);
      reset = 1;
      repeat (2) @(negedge clock);
      step("r_roll_idle", 3'b001, 5'd0);
      step("r_start2",    3'b100, 5'd0);

`ifdef DICE_INPUT_DEBOUNCE_EN
      // bounce on enter in GET_SIDES, then a clean hold
      model_step(3'b010, 5'd8, eo, en);
      io.sw_value = 5'd8;
      for (int p = 0; p < 4; p++) begin
         io.btn_enter = (p % 2 == 0);
         repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            check("bounce_no_press", outs, eo);
         end
      end
      io.btn_enter = 1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clock);
         @(negedge clock);
         if (k == LAT - 1) check("bounce_pre", outs, eo);
         if (k == LAT)     check("bounce_press", outs, en);
      end
      io.btn_enter = 0;
      repeat (LAT + 2) @(negedge clock);
`else
      // single-cycle glitch on roll is a full press without debounce
      step("g_sides", 3'b010, 5'd8);
      step("g_tgt",   3'b010, 5'd7);
      model_step(3'b001, 5'd0, eo, en);
      press("glitch_roll", 3'b001, 5'd0, 1, eo, en);
`endif

      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3)      msk = 3'b100;
         else if (r < 7) msk = 3'b010;
         else if (r < 9) msk = 3'b001;
         else            msk = 3'($urandom_range(3, 7));
         r = int'($urandom_range(0, 3));
         if (m_ph == 2 && r < 2 && m_sd != 0) sw = 5'($urandom_range(1, int'(m_sd)));
         else if (r == 0) sw = 5'd4 + 5'(2 * $urandom_range(0, 4));
         else if (r == 1) sw = 5'd20;
         else             sw = 5'($urandom_range(0, 31));
         step("rand", msk, sw);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
